pe_launch_ctrl: RTL and testbench

PE_LAUNCH_CTRL -- requirements
Module: pe_launch_ctrl

---
 rtl/pe_launch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pe_launch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_launch_ctrl.sv
// pe_launch_ctrl: launches a group of PEs for a number of start/done rounds.
// A command (PE mask + iteration count) is taken in IDLE. Each round pulses
// ap_start on the masked PEs for one cycle and then collects their ap_done
// bits until every masked PE has reported. All outputs are registered.
// Optional watchdog: define PE_LAUNCH_TIMEOUT_EN to bound the time spent
// waiting for done; without it WAIT waits indefinitely and timeout is 0.
module pe_launch_ctrl #(
  parameter int NUM_PE         = 4,
  parameter int ITER_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [NUM_PE-1:0]     cmd_pe_mask,
  input  logic [ITER_WIDTH-1:0] cmd_iters,
  input  logic                  abort,
  output logic [NUM_PE-1:0]     ap_start,
  input  logic [NUM_PE-1:0]     ap_done,
  output logic                  busy,
  output logic                  done_pulse,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  timeout
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                state_reg;
  logic [NUM_PE-1:0]     mask_reg;
  logic [ITER_WIDTH-1:0] iters_reg;
  logic [NUM_PE-1:0]     done_seen_reg;
  logic                  cmd_ready_reg;
  logic [NUM_PE-1:0]     ap_start_reg;
  logic                  busy_reg;
  logic                  done_pulse_reg;
  logic [ITER_WIDTH-1:0] iter_count_reg;

  // Done bits seen so far in this round, including this cycle's ap_done.
  logic [NUM_PE-1:0]     done_next;
  logic                  round_done;
  logic [ITER_WIDTH-1:0] iter_next;
  logic                  cmd_empty;
  logic                  wdog_hit;

  assign done_next  = done_seen_reg | (ap_done & mask_reg);
  assign round_done = (done_next == mask_reg);
  assign iter_next  = iter_count_reg + ITER_WIDTH'(1);
  assign cmd_empty  = (mask_reg == '0) || (iters_reg == '0);

`ifdef PE_LAUNCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt_reg;
  logic          timeout_reg;
  // Fires on the last permitted WAIT cycle so the state leaves WAIT after
  // exactly TIMEOUT_CYCLES cycles there.
  assign wdog_hit = (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
  assign timeout  = timeout_reg;
`else
  // Watchdog compiled out: no counter, flag permanently low. The limit
  // parameter is intentionally ignored in this build.
  assign wdog_hit = 1'b0;
  assign timeout  = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  assign cmd_ready  = cmd_ready_reg;
  assign ap_start   = ap_start_reg;
  assign busy       = busy_reg;
  assign done_pulse = done_pulse_reg;
  assign iter_count = iter_count_reg;

  // Launch FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      iters_reg      <= '0;
      done_seen_reg  <= '0;
      cmd_ready_reg  <= 1'b1;
      ap_start_reg   <= '0;
      busy_reg       <= 1'b0;
      done_pulse_reg <= 1'b0;
      iter_count_reg <= '0;
`ifdef PE_LAUNCH_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      timeout_reg    <= 1'b0;
`endif
    end else begin
      ap_start_reg   <= '0;
      done_pulse_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (cmd_valid) begin
            mask_reg       <= cmd_pe_mask;
            iters_reg      <= cmd_iters;
            iter_count_reg <= '0;
            cmd_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= START;
            // An empty command passes through START without starting a PE.
            ap_start_reg   <= (cmd_iters != '0) ? cmd_pe_mask : '0;
`ifdef PE_LAUNCH_TIMEOUT_EN
            timeout_reg    <= 1'b0;
`endif
          end
        end
        START: begin
          done_seen_reg <= '0;
`ifdef PE_LAUNCH_TIMEOUT_EN
          wait_cnt_reg  <= '0;
`endif
          if (abort) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else if (cmd_empty) begin
            state_reg      <= DONE;
            done_pulse_reg <= 1'b1;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end else if (round_done) begin
            iter_count_reg <= iter_next;
            done_seen_reg  <= '0;
            if (iter_next < iters_reg) begin
              state_reg    <= START;
              ap_start_reg <= mask_reg;
            end else begin
              state_reg      <= DONE;
              done_pulse_reg <= 1'b1;
            end
          end else if (wdog_hit) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
`ifdef PE_LAUNCH_TIMEOUT_EN
            timeout_reg   <= 1'b1;
`endif
          end else begin
            done_seen_reg <= done_next;
`ifdef PE_LAUNCH_TIMEOUT_EN
            wait_cnt_reg  <= wait_cnt_reg + TW'(1);
`endif
          end
        end
        DONE: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: begin
          state_reg     <= IDLE;
          cmd_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_launch_ctrl.sv
// tb_pe_launch_ctrl: directed and randomized launches of pe_launch_ctrl.
// Each launch is planned up front as a timeline (start cycles, per-PE done
// cycles, round completion cycles, done cycle, abort cycle) and every cycle
// of the launch is compared against that plan.
// Build with PE_LAUNCH_TIMEOUT_EN defined to also exercise the watchdog.
module tb_pe_launch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_pe_mask;
  logic [15:0] cmd_iters;
  logic        abort;
  logic [3:0]  ap_start;
  logic [3:0]  ap_done;
  logic        busy;
  logic        done_pulse;
  logic [15:0] iter_count;
  logic        timeout;

  int n_run  = 0;
  int n_fail = 0;
  int prev_ic = 0;
  bit to_flag = 1'b0;
  int dly_tab[4];

  localparam int NEVER = 1 << 30;

  pe_launch_ctrl #(
    .NUM_PE(4),
    .ITER_WIDTH(16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_pe_mask(cmd_pe_mask),
    .cmd_iters(cmd_iters),
    .abort(abort),
    .ap_start(ap_start),
    .ap_done(ap_done),
    .busy(busy),
    .done_pulse(done_pulse),
    .iter_count(iter_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int rel, input bit e_rdy, input bit e_busy,
                         input logic [3:0] e_ap, input bit e_dp, input int e_ic, input bit e_to);
    chk($sformatf("%s@%0d cmd_ready", tag, rel), 32'(cmd_ready), 32'(e_rdy));
    chk($sformatf("%s@%0d busy", tag, rel), 32'(busy), 32'(e_busy));
    chk($sformatf("%s@%0d ap_start", tag, rel), 32'(ap_start), 32'(e_ap));
    chk($sformatf("%s@%0d done_pulse", tag, rel), 32'(done_pulse), 32'(e_dp));
    chk($sformatf("%s@%0d iter_count", tag, rel), 32'(iter_count), 32'(e_ic));
    chk($sformatf("%s@%0d timeout", tag, rel), 32'(timeout), 32'(e_to));
  endtask

  // abort_sel: -1 none, -2 on the final round's completion cycle,
  // -3 random cycle of the launch, >=0 that relative cycle.
  task automatic run_launch(input string tag, input logic [3:0] m, input logic [15:0] it,
                            input int abort_sel, input bit use_tab, input int dmax);
    int st[8];
    int de[8];
    int dcy[8][4];
    int nr, s, fin, a, last, lim, cnt, d;
    bit degen;
    bit e_idle;
    logic [3:0] e_ap;
    logic [3:0] drv;
    degen = (m == 4'd0) || (it == 16'd0);
    nr = degen ? 0 : int'(it);
    s = 1;
    for (int k = 0; k < nr; k++) begin
      st[k] = s;
      de[k] = s;
      for (int p = 0; p < 4; p++) begin
        dcy[k][p] = 0;
        if (m[p]) begin
          d = use_tab ? dly_tab[p] : int'($urandom_range(1, dmax));
          dcy[k][p] = s + d;
          if (dcy[k][p] > de[k]) de[k] = dcy[k][p];
        end
      end
      s = de[k] + 1;
    end
    fin = degen ? 2 : s;
    if (abort_sel == -1) a = NEVER;
    else if (abort_sel == -2) a = de[nr-1];
    else if (abort_sel == -3) a = int'($urandom_range(1, fin));
    else a = abort_sel;
    last = (a < fin) ? a : fin;

    for (int rel = 0; rel <= last + 1; rel++) begin
      @(negedge clk);
      e_idle = (rel == 0) || (rel > last);
      e_ap = 4'd0;
      for (int k = 0; k < nr; k++)
        if (st[k] == rel && !e_idle) e_ap = m;
      lim = (rel < a) ? rel : a;
      cnt = 0;
      for (int k = 0; k < nr; k++)
        if (de[k] < lim) cnt++;
      if (rel == 0) cnt = prev_ic;
      chk_all(tag, rel, e_idle, !e_idle, e_ap, (rel == fin) && !e_idle, cnt,
              (rel == 0) ? to_flag : 1'b0);
      if (rel == last + 1) prev_ic = cnt;
      if (rel >= 1) to_flag = 1'b0;

      cmd_valid   = (rel == 0);
      cmd_pe_mask = (rel == 0) ? m  : 4'($urandom);
      cmd_iters   = (rel == 0) ? it : 16'($urandom);
      abort       = (rel == a) || (((rel == 0) || (rel == last + 1)) && $urandom_range(0, 1) == 1);
      drv = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        if (m[p]) begin
          for (int k = 0; k < nr; k++) begin
            if (rel > st[k] && rel <= de[k])
              drv[p] = (rel == dcy[k][p]) ? 1'b1 :
                       (rel > dcy[k][p]) ? 1'($urandom_range(0, 1)) : 1'b0;
          end
        end
      end
      ap_done = drv;
    end
    $display("[TB] %s mask=%b iters=%0d rounds=%0d done_at=%0d abort_at=%0d iter_count=%0d",
             tag, m, it, nr, fin, (a == NEVER) ? -1 : a, prev_ic);
  endtask

  initial begin
    bit e_busy, e_to;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_pe_mask = 4'd0;
    cmd_iters = 16'd0;
    abort = 1'b0;
    ap_done = 4'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk_all("reset", 0, 1'b1, 1'b0, 4'd0, 1'b0, 0, 1'b0);
    $display("[TB] reset applied");
    reset = 1'b0;

    // Two PEs, one round, staggered completion.
    dly_tab[0] = 3; dly_tab[1] = 1; dly_tab[2] = 5; dly_tab[3] = 1;
    run_launch("two_pe", 4'b0101, 16'd1, -1, 1'b1, 1);

    // Three rounds, all PEs complete together: starts six cycles apart.
    dly_tab[0] = 5; dly_tab[1] = 5; dly_tab[2] = 5; dly_tab[3] = 5;
    run_launch("three_rounds", 4'b1111, 16'd3, -1, 1'b1, 1);

    // Long wait with only unmasked PEs toggling before completion.
    dly_tab[0] = 12; dly_tab[1] = 12; dly_tab[2] = 12; dly_tab[3] = 12;
    run_launch("masked_off", 4'b0011, 16'd1, -1, 1'b1, 1);

    // Empty commands.
    run_launch("mask_zero", 4'b0000, 16'd2, -1, 1'b0, 4);
    run_launch("iters_zero", 4'b1010, 16'd0, -1, 1'b0, 4);

    // Abort on the same cycle as the final completion.
    run_launch("abort_final", 4'b0110, 16'd2, -2, 1'b0, 4);

    // Abort in START and in DONE.
    run_launch("abort_start", 4'b1001, 16'd2, 1, 1'b0, 4);
    dly_tab[0] = 2; dly_tab[1] = 2; dly_tab[2] = 2; dly_tab[3] = 2;
    run_launch("abort_done", 4'b0001, 16'd1, 4, 1'b1, 1);

    // Stall: the only masked PE never reports.
    @(negedge clk);
    chk("stall@0 cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_pe_mask = 4'b0001; cmd_iters = 16'd1; abort = 1'b0; ap_done = 4'd0;
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
`ifdef PE_LAUNCH_TIMEOUT_EN
      e_busy = (rel < 18);
      e_to   = (rel >= 18);
`else
      e_busy = 1'b1;
      e_to   = 1'b0;
`endif
      chk_all("stall", rel, !e_busy, e_busy, (rel == 1) ? 4'b0001 : 4'b0000, 1'b0, 0, e_to);
      cmd_valid = 1'b0;
      ap_done = 4'($urandom) & 4'b1110;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("stall_end busy", 32'(busy), 32'd0);
    chk("stall_end cmd_ready", 32'(cmd_ready), 32'd1);
`ifdef PE_LAUNCH_TIMEOUT_EN
    to_flag = 1'b1;
`else
    to_flag = 1'b0;
`endif
    prev_ic = 0;
    $display("[TB] stall mask=0001 iters=1 timeout=%0d", to_flag);

    // Next command clears the watchdog flag.
    dly_tab[0] = 2; dly_tab[1] = 3; dly_tab[2] = 4; dly_tab[3] = 1;
    run_launch("after_stall", 4'b1111, 16'd1, -1, 1'b1, 1);

    // Reset while ap_start is high.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_pe_mask = 4'b1111; cmd_iters = 16'd2;
    @(negedge clk);
    chk("midreset ap_start_before", 32'(ap_start), 32'hF);
    cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_all("midreset", 2, 1'b1, 1'b0, 4'd0, 1'b0, 0, 1'b0);
    reset = 1'b0;
    prev_ic = 0;
    to_flag = 1'b0;
    $display("[TB] reset during launch");

    // Randomized launches.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] m;
      logic [15:0] it;
      m  = 4'($urandom);
      it = 16'($urandom_range(0, 3));
      run_launch($sformatf("rand%0d", n), m, it, ($urandom_range(0, 3) == 0) ? -3 : -1,
                 1'b0, 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
